// File: rtl/conv_pkg.sv
// Shared constants and types for the conv_gauss 1x3 horizontal Gaussian smoother.
// Build option: define CONV_GAUSS_ROUND_EN for round-half-up; otherwise results are truncated.
package conv_pkg;

    localparam int PIXEL_WIDTH   = 8;
    localparam int WORD_WIDTH    = 128;
    localparam int LANES         = WORD_WIDTH / PIXEL_WIDTH;
    localparam int IMAGE_WIDTH   = 512;
    localparam int BEATS_PER_ROW = IMAGE_WIDTH / LANES;

`ifdef CONV_GAUSS_ROUND_EN
    localparam int RND = 2;
`else
    localparam int RND = 0;
`endif

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef pixel_t [LANES-1:0]     beat_t;

endpackage

// File: rtl/gauss_tap3.sv
// One lane of the 1-2-1 kernel: y = (l + 2c + r + RND) >> 2, using two guard bits.
module gauss_tap3
    import conv_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic [PW-1:0] l,
    input  logic [PW-1:0] c,
    input  logic [PW-1:0] r,
    output logic [PW-1:0] y
);

    logic [PW+1:0] sum;

    // Worst case 4*(2^PW-1)+2 still fits in PW+2 bits, so no saturation is needed.
    assign sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + (PW+2)'(RND);
    assign y   = sum[PW+1:2];

endmodule

// File: rtl/conv_gauss.sv
// Streaming 1x3 Gaussian smoother over 16-pixel beats, edge pixels replicated at row ends.
// Rounding selected at build time by CONV_GAUSS_ROUND_EN (see conv_pkg).
module conv_gauss #(
    parameter int PIXEL_WIDTH = 8,
    parameter int WORD_WIDTH  = 128,
    parameter int IMAGE_WIDTH = 512
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  stall,
    input  logic [WORD_WIDTH-1:0] s_axis_tdata,
    output logic [WORD_WIDTH-1:0] m_axis_tdata
);

    localparam int LANES = WORD_WIDTH / PIXEL_WIDTH;
    localparam int BEATS = IMAGE_WIDTH / LANES;
    localparam int COL_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef logic [LANES-1:0][PIXEL_WIDTH-1:0] beat_t;
    typedef logic [COL_W-1:0]                  col_t;

    // W2 only ever supplies a left neighbour, so it needs no column tag or valid bit.
    beat_t w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    col_t  col0_q, col0_d, col1_q, col1_d;
    logic  vld0_q, vld0_d, vld1_q, vld1_d;
    col_t  col_cnt_q, col_cnt_d;
    beat_t out_q, out_d;
    beat_t filt;

    logic row_start, row_end;
    assign row_start = (col1_q == '0);
    assign row_end   = (col1_q == COL_W'(BEATS - 1));

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [PIXEL_WIDTH-1:0] left_px, right_px;

        if (gi == LANES - 1) begin : g_left_edge
            assign left_px = row_start ? w1_q[gi] : w2_q[0];
        end else begin : g_left_int
            assign left_px = w1_q[gi+1];
        end

        if (gi == 0) begin : g_right_edge
            assign right_px = row_end ? w1_q[gi] : w0_q[LANES-1];
        end else begin : g_right_int
            assign right_px = w1_q[gi-1];
        end

        gauss_tap3 #(.PW(PIXEL_WIDTH)) u_tap (
            .l(left_px),
            .c(w1_q[gi]),
            .r(right_px),
            .y(filt[gi])
        );
    end

    always_comb begin
        w0_d      = w0_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        col0_d    = col0_q;
        col1_d    = col1_q;
        vld0_d    = vld0_q;
        vld1_d    = vld1_q;
        col_cnt_d = col_cnt_q;
        out_d     = out_q;
        if (!stall) begin
            w2_d      = w1_q;
            w1_d      = w0_q;
            w0_d      = beat_t'(s_axis_tdata);
            col1_d    = col0_q;
            col0_d    = col_cnt_q;
            vld1_d    = vld0_q;
            vld0_d    = 1'b1;
            col_cnt_d = (col_cnt_q == COL_W'(BEATS - 1)) ? '0 : col_cnt_q + 1'b1;
            if (vld1_q) begin
                out_d = filt;
            end
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            w0_q      <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            col0_q    <= '0;
            col1_q    <= '0;
            vld0_q    <= 1'b0;
            vld1_q    <= 1'b0;
            col_cnt_q <= '0;
            out_q     <= '0;
        end else begin
            w0_q      <= w0_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            col0_q    <= col0_d;
            col1_q    <= col1_d;
            vld0_q    <= vld0_d;
            vld1_q    <= vld1_d;
            col_cnt_q <= col_cnt_d;
            out_q     <= out_d;
        end
    end

    assign m_axis_tdata = WORD_WIDTH'(out_q);

endmodule

// File: tb/tb_conv_gauss.sv
// Directed bench for conv_gauss: a reference model queues expected beats, popped after each edge.
module tb_conv_gauss;

    typedef logic [15:0][7:0] beat_t;

`ifdef CONV_GAUSS_ROUND_EN
    localparam int RND = 2;
`else
    localparam int RND = 0;
`endif

    logic         clk = 1'b0;
    logic         aresetn;
    logic         stall;
    logic [127:0] tdata;
    logic [127:0] mdata;

    int checks = 0;
    int errors = 0;

    beat_t hist[$];
    beat_t exp_q[$];
    beat_t last_exp;
    int    out_idx;

    conv_gauss dut (
        .s_axis_aclk   (clk),
        .s_axis_aresetn(aresetn),
        .stall         (stall),
        .s_axis_tdata  (tdata),
        .m_axis_tdata  (mdata)
    );

    always #5 clk = ~clk;

    // Reference: filtered beat for history index j, with row-edge replication.
    function automatic beat_t model(int j);
        beat_t res;
        int    c = j % 32;
        beat_t cur = hist[j];
        for (int i = 0; i < 16; i++) begin
            int l, r, s;
            if (i == 15) l = (c == 0) ? int'(cur[i]) : int'(hist[j-1][0]);
            else         l = int'(cur[i+1]);
            if (i == 0)  r = (c == 31) ? int'(cur[i]) : int'(hist[j+1][15]);
            else         r = int'(cur[i-1]);
            s = (l + 2 * int'(cur[i]) + r + RND) >> 2;
            res[i] = 8'(s);
        end
        return res;
    endfunction

    task automatic check(input string tag, input int idx, input beat_t obs, input beat_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s #%0d observed=%h expected=%h", tag, idx, obs, expv);
        end
    endtask

    task automatic step(input beat_t d, input logic st);
        tdata = d;
        stall = st;
        if (!st) begin
            hist.push_back(d);
            if (hist.size() >= 3) exp_q.push_back(model(hist.size() - 3));
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) last_exp = exp_q.pop_front();
        check(st ? "stall_hold" : "out", out_idx, beat_t'(mdata), last_exp);
        out_idx++;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        stall   = 1'b1;
        tdata   = {16{8'h5A}};
        @(posedge clk);
        #1;
        hist.delete();
        exp_q.delete();
        last_exp = '0;
        check("reset_zero", out_idx, beat_t'(mdata), '0);
        aresetn = 1'b1;
        stall   = 1'b0;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    initial begin
        beat_t b;
        aresetn  = 1'b0;
        stall    = 1'b0;
        tdata    = '0;
        last_exp = '0;
        out_idx  = 0;
        @(posedge clk);
        do_reset();

        // Constant field: output must settle to 0x80 everywhere, edges included.
        for (int k = 0; k < 64; k++) step({16{8'h80}}, 1'b0);

        // Alternating 0/1 row exercises rounding on interior lanes.
        for (int i = 0; i < 16; i++) b[i] = (i % 2 == 0) ? 8'd1 : 8'd0;
        for (int k = 0; k < 32; k++) step(b, 1'b0);

        // Edge replication and cross-beat neighbours (this row starts at column 0).
        for (int k = 0; k < 32; k++) begin
            b = '0;
            if (k == 0)  b[15] = 8'hFF;
            if (k == 31) b[0]  = 8'hFF;
            if (k == 5)  b[0]  = 8'h40;
            if (k == 6)  b[15] = 8'hC0;
            step(b, 1'b0);
        end

        // Random row with a 3-cycle stall in the middle.
        for (int k = 0; k < 32; k++) begin
            if (k == 10) for (int s = 0; s < 3; s++) step(rand_beat(), 1'b1);
            step(rand_beat(), 1'b0);
        end

        // Reset mid-row at column 17, then a fresh stream and a flush beat.
        for (int k = 0; k < 17; k++) step(rand_beat(), 1'b0);
        do_reset();
        for (int k = 0; k < 34; k++) step(rand_beat(), 1'b0);
        step(rand_beat(), 1'b0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
